// File: rtl/tt_um_trivium_lite_dec.sv
// ---------------------------------------------------------------------------
// tt_um_trivium_lite_dec
// Purpose : receive-side Trivium-lite tile. A seed byte restarts the keystream
//           generator. Each incoming ciphertext byte is XORed with the current
//           keystream byte to give plaintext, which is held on uo_out until the
//           sink takes it.
// Ports   : clk, rst_n (async active-low), ena (ignored)
//           ui_in   [7:0] seed (uio_in[1]=1) or ciphertext byte
//           uio_in  [0] in_valid [1] is_seed [2] resync [3] out_ready
//           uo_out  [7:0] plaintext, valid while out_valid=1
//           uio_out [4] in_ready [5] out_valid [6] locked [7] err, [3:0]=0
//           uio_oe  constant 8'hF0
// Options : define TRIVIUM_DEC_ERR_EN to drive uio_out[7] with a one-cycle
//           error pulse. The pulse fires on a rejected seed (00/FF) or on
//           ciphertext received while unlocked. Otherwise uio_out[7] is 0.
// ---------------------------------------------------------------------------
module tt_um_trivium_lite_dec #(
  parameter logic [7:0]  SEED_MASK = 8'hA5,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t           r_state;
  logic [7:0]       r_s1;
  logic [7:0]       r_s2;
  logic [7:0]       r_s3;
  logic [7:0]       r_ks;
  logic [2:0]       r_step;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_uo;
  logic             r_out_valid;
  logic             r_locked;

  logic w_in_valid;
  logic w_is_seed;
  logic w_resync;
  logic w_out_ready;
  logic w_in_ready;
  logic w_xfer;
  logic w_seed_xfer;
  logic w_cipher_xfer;
  logic w_seed_ok;
  logic w_err;
  logic w_b;
  logic [7:0] w_s1_nxt;
  logic [7:0] w_s2_nxt;
  logic [7:0] w_s3_nxt;
  logic w_unused;

  assign w_in_valid  = uio_in[0];
  assign w_is_seed   = uio_in[1];
  assign w_resync    = uio_in[2];
  assign w_out_ready = uio_in[3];

  // Seeds are always accepted. Ciphertext is accepted when unlocked (to be
  // dropped) or when a keystream byte is ready and the output slot frees up.
  // Held low while in reset so the pins read all-zero.
  assign w_in_ready = rst_n & (w_is_seed | (r_state == ST_IDLE) |
                      ((r_state == ST_WAIT) & (~r_out_valid | w_out_ready)));

  assign w_xfer        = w_in_valid & w_in_ready;
  assign w_seed_xfer   = w_xfer & w_is_seed;
  assign w_cipher_xfer = w_xfer & ~w_is_seed;
  assign w_seed_ok     = (ui_in != 8'h00) && (ui_in != 8'hFF);

  // One keystream step; must stay bit-identical to the encryptor tile.
  assign w_b      = r_s1[0] ^ r_s2[0] ^ r_s3[0];
  assign w_s1_nxt = {r_s1[6:0], r_s2[0] ^ r_s3[1]};
  assign w_s2_nxt = {r_s2[6:0], r_s3[3] ^ r_s1[1]};
  assign w_s3_nxt = {r_s3[6:0], r_s1[5] ^ r_s2[2]};

  // Main control FSM and datapath; resync acts as a synchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_s1        <= 8'd1;
      r_s2        <= 8'd2;
      r_s3        <= 8'd3;
      r_ks        <= 8'd0;
      r_step      <= 3'd0;
      r_cnt       <= '0;
      r_uo        <= 8'd0;
      r_out_valid <= 1'b0;
      r_locked    <= 1'b0;
    end else if (w_resync) begin
      r_state     <= ST_IDLE;
      r_s1        <= 8'd1;
      r_s2        <= 8'd2;
      r_s3        <= 8'd3;
      r_ks        <= 8'd0;
      r_step      <= 3'd0;
      r_cnt       <= '0;
      r_uo        <= 8'd0;
      r_out_valid <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      if (w_out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_seed_xfer && w_seed_ok) begin
        // Valid seed restarts generation; a pending plaintext byte is kept.
        r_s1     <= ui_in;
        r_s2     <= {~ui_in[3:0], ui_in[7:4]};
        r_s3     <= ui_in ^ SEED_MASK;
        r_ks     <= 8'd0;
        r_step   <= 3'd0;
        r_cnt    <= '0;
        r_locked <= 1'b1;
        r_state  <= ST_GEN;
      end else if (!w_seed_xfer) begin
        unique case (r_state)
          ST_IDLE: begin
            // Ciphertext while unlocked is consumed and dropped.
          end
          ST_GEN: begin
            r_s1   <= w_s1_nxt;
            r_s2   <= w_s2_nxt;
            r_s3   <= w_s3_nxt;
            r_ks   <= {r_ks[6:0], w_b};
            r_step <= r_step + 3'd1;
            if (r_step == 3'd7) begin
              r_state <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (w_cipher_xfer) begin
              r_uo        <= ui_in ^ r_ks;
              r_out_valid <= 1'b1;
              r_cnt       <= r_cnt + CNT_W'(1);
              r_step      <= 3'd0;
              r_state     <= ST_GEN;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef TRIVIUM_DEC_ERR_EN
  logic r_err;

  // One-cycle pulse on a rejected seed or ciphertext arriving while unlocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_resync) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (w_seed_xfer & ~w_seed_ok) |
               (w_cipher_xfer & (r_state == ST_IDLE));
    end
  end

  assign w_err = r_err;
`else
  assign w_err = 1'b0;
`endif

  assign uo_out  = r_uo;
  assign uio_out = {w_err, r_locked, r_out_valid, w_in_ready, 4'b0000};
  assign uio_oe  = 8'hF0;

  // The byte counter and these pins have no observable output.
  assign w_unused = &{1'b0, ena, uio_in[7:4], r_cnt};

endmodule

// File: tb/tb_tt_um_trivium_lite_dec.sv
// Scoreboard bench for tt_um_trivium_lite_dec. The driver encrypts plaintext
// with a behavioural keystream model and queues the plaintext it expects back.
// The monitor pops and compares each time the DUT hands over a byte.
module tb_tt_um_trivium_lite_dec;

`ifdef TRIVIUM_DEC_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic       in_valid = 1'b0;
  logic       is_seed = 1'b0;
  logic       resync = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  assign uio_in = {4'b0000, out_ready, resync, is_seed, in_valid};

  wire in_ready  = uio_out[4];
  wire out_valid = uio_out[5];
  wire locked    = uio_out[6];
  wire err       = uio_out[7];

  tt_um_trivium_lite_dec dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  int   or_mode = 0;       // 0: out_ready = or_dir, 1: random
  logic or_dir  = 1'b1;
  logic [7:0] m_s1, m_s2, m_s3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Keystream reference: seed expansion and 8 generator steps per byte.
  task automatic model_load(input logic [7:0] seed);
    m_s1 = seed;
    m_s2 = {~seed[3:0], seed[7:4]};
    m_s3 = seed ^ 8'hA5;
  endtask

  task automatic model_next(output logic [7:0] ks);
    logic b, n1, n2, n3;
    ks = 8'h00;
    for (int i = 0; i < 8; i++) begin
      b  = m_s1[0] ^ m_s2[0] ^ m_s3[0];
      n1 = m_s2[0] ^ m_s3[1];
      n2 = m_s3[3] ^ m_s1[1];
      n3 = m_s1[5] ^ m_s2[2];
      m_s1 = 8'((m_s1 << 1) | {7'd0, n1});
      m_s2 = 8'((m_s2 << 1) | {7'd0, n2});
      m_s3 = 8'((m_s3 << 1) | {7'd0, n3});
      ks   = 8'((ks << 1) | {7'd0, b});
    end
  endtask

  // Sink back-pressure, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    out_ready = (or_mode == 1) ? ($urandom_range(0, 3) != 0) : or_dir;
  end

  // Monitor: a byte is handed over when out_valid and out_ready meet an edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got %02h with nothing expected", uo_out);
      end else begin
        chk("plaintext", 32'(uo_out), 32'(exp_q.pop_front()));
      end
    end
  end

  // Present one byte and hold it until accepted; called just after a rising edge.
  task automatic send(input logic seed, input logic [7:0] d, output bit got);
    got = 1'b0;
    in_valid = 1'b1;
    is_seed  = seed;
    ui_in    = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    is_seed  = 1'b0;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: byte %02h not accepted, expected acceptance", d);
    end
  endtask

  task automatic send_seed(input logic [7:0] s);
    bit got;
    send(1'b1, s, got);
    if (got && s != 8'h00 && s != 8'hFF) model_load(s);
  endtask

  task automatic send_pt(input logic [7:0] p);
    bit got;
    logic [7:0] ks;
    model_next(ks);
    send(1'b0, p ^ ks, got);
    if (got) exp_q.push_back(p);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit got;
    int n;
    logic [7:0] p;

    // Reset values
    #3 rst_n = 1'b0;
    #4;
    chk("rst_uo_out", 32'(uo_out), 32'h00);
    chk("rst_uio_out", 32'(uio_out), 32'h00);
    chk("rst_uio_oe", 32'(uio_oe), 32'hF0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_locked", 32'(locked), 32'd0);

    // Rejected seeds while unlocked
    send_seed(8'hFF);
    @(negedge clk);
    chk("ff_locked", 32'(locked), 32'd0);
    chk("ff_err", 32'(err), 32'(ERR_EN));
    @(negedge clk);
    chk("ff_err_clear", 32'(err), 32'd0);
    @(posedge clk); #1;
    send_seed(8'h00);
    @(negedge clk);
    chk("00_locked", 32'(locked), 32'd0);
    chk("00_err", 32'(err), 32'(ERR_EN));
    @(negedge clk);
    chk("00_err_clear", 32'(err), 32'd0);

    // Ciphertext while unlocked is swallowed
    @(posedge clk); #1;
    send(1'b0, 8'h55, got);
    @(negedge clk);
    chk("idle_ct_err", 32'(err), 32'(ERR_EN));
    chk("idle_ct_out_valid", 32'(out_valid), 32'd0);
    chk("idle_ct_uo_out", 32'(uo_out), 32'h00);

    // Seed 01: 8 generate cycles, then cipher 82 decrypts to 00
    @(posedge clk); #1;
    send_seed(8'h01);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
    end
    chk("gen_cycles", 32'(n), 32'd8);
    chk("seed_locked", 32'(locked), 32'd1);
    @(posedge clk); #1;
    send(1'b0, 8'h82, got);
    if (got) exp_q.push_back(8'h00);
    @(negedge clk);
    chk("first_out_valid", 32'(out_valid), 32'd1);
    chk("first_uo_out", 32'(uo_out), 32'h00);
    @(posedge clk); #1;
    send_seed(8'h01);
    send(1'b0, 8'h41, got);
    if (got) exp_q.push_back(8'hC3);
    drain();

    // Back-pressure: output held, input stalled, then flow resumes
    send_seed(8'h5A);
    or_dir = 1'b0;
    send_pt(8'h3C);
    repeat (12) @(posedge clk);
    #1;
    is_seed = 1'b0;
    @(negedge clk);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_uo_hold", 32'(uo_out), 32'h3C);
    @(posedge clk); #1;
    or_dir = 1'b1;
    send_pt(8'hE7);
    send_pt(8'h81);
    drain();

    // Resync in the middle of generation, with a byte still pending
    send_seed(8'h77);
    or_dir = 1'b0;
    send_pt(8'h99);
    repeat (4) @(posedge clk);
    #1;
    resync = 1'b1;
    @(posedge clk); #1;
    resync = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rs_uo_out", 32'(uo_out), 32'h00);
    chk("rs_out_valid", 32'(out_valid), 32'd0);
    chk("rs_locked", 32'(locked), 32'd0);
    chk("rs_err", 32'(err), 32'd0);
    chk("rs_in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    or_dir = 1'b1;

    // Asynchronous reset during generation
    send_seed(8'h3B);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_uio_out", 32'(uio_out), 32'h00);
    chk("ar_uo_out", 32'(uo_out), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ar_locked", 32'(locked), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd1);

    // Randomised loopback against the encryptor model, 300 bytes with reseeds
    send_seed(8'(($urandom_range(1, 254))));
    or_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 63) == 0) send_seed(8'(($urandom_range(1, 254))));
      p = 8'($urandom_range(0, 255));
      send_pt(p);
    end
    or_mode = 0;
    or_dir  = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1);
  end

endmodule
